// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite definitions for the address splitter: data-phase states,
// response and transfer encodings, region width and the default read pattern.
package ahbl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SLV,
    ST_ERR1,
    ST_ERR2,
    ST_TOUT1,
    ST_TOUT2
  } state_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam int REGION_W = 4;

  localparam logic [31:0] DFLT_RDATA_DEFAULT = 32'hBADDBEEF;

endpackage

// File: rtl/ahbl_default_slave.sv
// Built-in default slave: sequences the two-cycle AHB ERROR response that
// serves both unmapped accesses (ERR1/ERR2) and watchdog aborts (TOUT1/TOUT2).
module ahbl_default_slave
  import ahbl_pkg::*;
(
  input  state_t state,
  output logic   hready,
  output logic   hresp,
  output logic   irq,
  output state_t next_state
);

  always_comb begin
    hready     = 1'b1;
    hresp      = HRESP_OKAY;
    irq        = 1'b0;
    next_state = state;
    case (state)
      ST_ERR1: begin
        hready     = 1'b0;
        hresp      = HRESP_ERROR;
        next_state = ST_ERR2;
      end
      ST_TOUT1: begin
        hready     = 1'b0;
        hresp      = HRESP_ERROR;
        irq        = 1'b1;
        next_state = ST_TOUT2;
      end
      // Second cycle drives HREADY high, so the splitter always accepts the
      // next address phase here and overrides next_state.
      ST_ERR2, ST_TOUT2: begin
        hready     = 1'b1;
        hresp      = HRESP_ERROR;
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/ahbl_splitter_n.sv
// AHB-Lite splitter: one master to NSLV slaves on a HADDR[31:28] region decode,
// with a default ERROR slave, a data-phase stall watchdog and sticky error capture.
module ahbl_splitter_n
  import ahbl_pkg::*;
#(
  parameter int              NSLV       = 4,
  parameter logic [4*NSLV-1:0] SLV_TAGS = {4'h8, 4'h4, 4'h2, 4'h0},
  parameter int              TIMEOUT    = 255,
  parameter logic [31:0]     DFLT_RDATA = DFLT_RDATA_DEFAULT
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [31:0]          HADDR,
  input  logic [1:0]           HTRANS,
  output logic                 HREADY,
  output logic [31:0]          HRDATA,
  output logic                 HRESP,
  output logic [NSLV-1:0]      S_HSEL,
  input  logic [32*NSLV-1:0]   S_HRDATA,
  input  logic [NSLV-1:0]      S_HREADYOUT,
  input  logic [NSLV-1:0]      S_HRESP,
  output logic                 ERR_VALID,
  output logic                 ERR_TOUT,
  output logic [31:0]          ERR_ADDR,
  input  logic                 ERR_CLR,
  output logic                 TOUT_IRQ
);

  localparam int IDX_W   = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WDOG_ON = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t            state;
  state_t            next_state;
  logic [IDX_W-1:0]  sel_q;
  logic [31:0]       addr_q;
  logic [CNT_W-1:0]  cnt;

  logic [NSLV-1:0]   hsel;
  logic              hit;
  logic [IDX_W-1:0]  hit_idx;
  logic              xfer;

  logic [31:0]       s_rdata;
  logic              s_ready;
  logic              s_resp;
  logic              stall_hit;

  logic              hready_c;
  logic              hresp_c;
  logic [31:0]       rdata_c;

  logic              d_hready;
  logic              d_hresp;
  logic              d_irq;
  state_t            d_next;

  logic              err_valid;
  logic              err_tout;
  logic [31:0]       err_addr;
  logic              err_entry;
  logic [31:0]       entry_addr;

  assign xfer = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);

  // Lowest matching index wins so overlapping tags still give a one-hot select.
  always_comb begin
    hsel    = '0;
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (!hit && (HADDR[31:32-REGION_W] == SLV_TAGS[REGION_W*i +: REGION_W])) begin
        hsel[i] = 1'b1;
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign S_HSEL = hsel;

  always_comb begin
    s_rdata = '0;
    s_ready = 1'b1;
    s_resp  = HRESP_OKAY;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_q == IDX_W'(i)) begin
        s_rdata = S_HRDATA[32*i +: 32];
        s_ready = S_HREADYOUT[i];
        s_resp  = S_HRESP[i];
      end
    end
  end

  assign stall_hit = WDOG_ON && (state == ST_SLV) && !s_ready && (cnt == CNT_LAST);

  ahbl_default_slave u_dflt (
    .state      (state),
    .hready     (d_hready),
    .hresp      (d_hresp),
    .irq        (d_irq),
    .next_state (d_next)
  );

  always_comb begin
    next_state = state;
    hready_c   = 1'b1;
    hresp_c    = HRESP_OKAY;
    rdata_c    = DFLT_RDATA;
    case (state)
      ST_IDLE: begin
        hready_c = 1'b1;
      end
      ST_SLV: begin
        hready_c = s_ready;
        hresp_c  = s_resp;
        rdata_c  = s_rdata;
        if (stall_hit) begin
          next_state = ST_TOUT1;
        end
      end
      default: begin
        hready_c   = d_hready;
        hresp_c    = d_hresp;
        next_state = d_next;
      end
    endcase
    if (hready_c) begin
      next_state = xfer ? (hit ? ST_SLV : ST_ERR1) : ST_IDLE;
    end
  end

  assign HREADY   = hready_c;
  assign HRESP    = hresp_c;
  assign HRDATA   = rdata_c;
  assign TOUT_IRQ = d_irq;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state  <= ST_IDLE;
      sel_q  <= '0;
      addr_q <= '0;
    end else begin
      state <= next_state;
      if (hready_c) begin
        sel_q  <= hit_idx;
        addr_q <= HADDR;
      end
    end
  end

  // Saturating stall counter; only meaningful while a slave holds HREADYOUT low.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      cnt <= '0;
    end else if (hready_c) begin
      cnt <= '0;
    end else if ((state == ST_SLV) && !s_ready && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // On ERR1 entry the faulting address is the one being accepted this cycle.
  assign err_entry  = ((next_state == ST_ERR1) || (next_state == ST_TOUT1)) && !err_valid;
  assign entry_addr = hready_c ? HADDR : addr_q;

  always_ff @(posedge HCLK) begin
    if (HRESET || ERR_CLR) begin
      err_valid <= 1'b0;
      err_tout  <= 1'b0;
      err_addr  <= '0;
    end else if (err_entry) begin
      err_valid <= 1'b1;
      err_tout  <= (next_state == ST_TOUT1);
      err_addr  <= entry_addr;
    end
  end

  assign ERR_VALID = err_valid;
  assign ERR_TOUT  = err_tout;
  assign ERR_ADDR  = err_addr;

endmodule

// File: tb/tb_ahbl_splitter_n.sv
// Scoreboard bench for ahbl_splitter_n: directed transfers push expected data-phase
// responses; a monitor pops and compares them whenever a data phase completes.
`timescale 1ns/1ps
module tb_ahbl_splitter_n;
  import ahbl_pkg::*;

  localparam int NSLV = 4;

  typedef struct {
    logic [31:0] rdata;
    logic        resp;
    logic        chk_rdata;
  } exp_t;

  logic              HCLK;
  logic              HRESET;
  logic [31:0]       HADDR;
  logic [1:0]        HTRANS;
  logic              HREADY;
  logic [31:0]       HRDATA;
  logic              HRESP;
  logic [NSLV-1:0]   S_HSEL;
  logic [32*NSLV-1:0] S_HRDATA;
  logic [NSLV-1:0]   S_HREADYOUT;
  logic [NSLV-1:0]   S_HRESP;
  logic              ERR_VALID;
  logic              ERR_TOUT;
  logic [31:0]       ERR_ADDR;
  logic              ERR_CLR;
  logic              TOUT_IRQ;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  logic dphase;

  ahbl_splitter_n #(
    .NSLV       (NSLV),
    .SLV_TAGS   ({4'h0, 4'h4, 4'h2, 4'h0}),
    .TIMEOUT    (8),
    .DFLT_RDATA (32'hBADDBEEF)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HREADY      (HREADY),
    .HRDATA      (HRDATA),
    .HRESP       (HRESP),
    .S_HSEL      (S_HSEL),
    .S_HRDATA    (S_HRDATA),
    .S_HREADYOUT (S_HREADYOUT),
    .S_HRESP     (S_HRESP),
    .ERR_VALID   (ERR_VALID),
    .ERR_TOUT    (ERR_TOUT),
    .ERR_ADDR    (ERR_ADDR),
    .ERR_CLR     (ERR_CLR),
    .TOUT_IRQ    (TOUT_IRQ)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: bound expired", name);
  endtask

  // Drive one address phase and return once it has been accepted.
  task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] trans,
                               input logic push, input logic [31:0] exp_rdata,
                               input logic exp_resp, input logic chk_rd,
                               output logic [NSLV-1:0] sel_seen);
    exp_t e;
    int   budget;
    HADDR  = addr;
    HTRANS = trans;
    if (push) begin
      e.rdata     = exp_rdata;
      e.resp      = exp_resp;
      e.chk_rdata = chk_rd;
      sb_q.push_back(e);
    end
    budget = 0;
    @(negedge HCLK);
    while (!HREADY && budget < 64) begin
      budget++;
      @(negedge HCLK);
    end
    if (!HREADY) failNow("accept_wait");
    sel_seen = S_HSEL;
    @(posedge HCLK);
    #1;
  endtask

  task automatic setIdle();
    HTRANS = HTRANS_IDLE;
  endtask

  task automatic pulseClear();
    ERR_CLR = 1'b1;
    @(posedge HCLK);
    #1;
    ERR_CLR = 1'b0;
  endtask

  // Monitor: pops one expectation each time a data phase completes.
  initial begin
    exp_t e;
    dphase = 1'b0;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        dphase = 1'b0;
      end else begin
        if (dphase && HREADY) begin
          if (sb_q.size() == 0) begin
            failNow("sb_underflow");
          end else begin
            e = sb_q.pop_front();
            checkOutput("sb_resp", {31'b0, HRESP}, {31'b0, e.resp});
            if (e.chk_rdata) checkOutput("sb_rdata", HRDATA, e.rdata);
          end
        end
        if (HREADY) dphase = HTRANS[1];
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    logic [NSLV-1:0] sel;
    int stall, tlow, irqn, cyc;
    bit done;

    HRESET      = 1'b1;
    HADDR       = 32'h4000_0000;
    HTRANS      = HTRANS_IDLE;
    ERR_CLR     = 1'b0;
    S_HRDATA    = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1234_5678};
    S_HREADYOUT = '1;
    S_HRESP     = '0;

    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    checkOutput("rst_hready", {31'b0, HREADY}, 32'd1);
    checkOutput("rst_hresp", {31'b0, HRESP}, 32'd0);
    checkOutput("rst_hrdata", HRDATA, 32'hBADDBEEF);
    checkOutput("rst_err_valid", {31'b0, ERR_VALID}, 32'd0);
    checkOutput("rst_err_tout", {31'b0, ERR_TOUT}, 32'd0);
    checkOutput("rst_err_addr", ERR_ADDR, 32'd0);
    checkOutput("rst_tout_irq", {31'b0, TOUT_IRQ}, 32'd0);
    checkOutput("rst_hsel", {28'b0, S_HSEL}, 32'h4);
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;

    // Read slave 0; slave 3 shares tag 0 so only bit 0 may be selected.
    applyStimulus(32'h0000_0010, HTRANS_NONSEQ, 1'b1, 32'h1234_5678, 1'b0, 1'b1, sel);
    checkOutput("rd0_hsel", {28'b0, sel}, 32'h1);
    applyStimulus(32'h0000_0000, HTRANS_IDLE, 1'b0, 32'h0, 1'b0, 1'b0, sel);

    // Slave ERROR passes through without touching the capture.
    S_HRESP[1] = 1'b1;
    applyStimulus(32'h2000_0000, HTRANS_NONSEQ, 1'b1, 32'h2222_0001, 1'b1, 1'b1, sel);
    checkOutput("rd1_hsel", {28'b0, sel}, 32'h2);
    applyStimulus(32'h0000_0000, HTRANS_IDLE, 1'b0, 32'h0, 1'b0, 1'b0, sel);
    S_HRESP[1] = 1'b0;
    checkOutput("slv_err_no_capture", {31'b0, ERR_VALID}, 32'd0);

    // BUSY to an unmapped region is not a transfer.
    applyStimulus(32'hF000_0000, HTRANS_BUSY, 1'b0, 32'h0, 1'b0, 1'b0, sel);
    setIdle();
    @(negedge HCLK);
    checkOutput("busy_hresp", {31'b0, HRESP}, 32'd0);
    checkOutput("busy_err_valid", {31'b0, ERR_VALID}, 32'd0);
    @(posedge HCLK);
    #1;

    // Decode error.
    applyStimulus(32'hF000_0000, HTRANS_NONSEQ, 1'b1, 32'hBADDBEEF, 1'b1, 1'b1, sel);
    checkOutput("unmapped_hsel", {28'b0, sel}, 32'h0);
    setIdle();
    @(negedge HCLK);
    checkOutput("err1_hready", {31'b0, HREADY}, 32'd0);
    checkOutput("err1_hresp", {31'b0, HRESP}, 32'd1);
    checkOutput("dec_err_valid", {31'b0, ERR_VALID}, 32'd1);
    checkOutput("dec_err_tout", {31'b0, ERR_TOUT}, 32'd0);
    checkOutput("dec_err_addr", ERR_ADDR, 32'hF000_0000);
    applyStimulus(32'h0000_0000, HTRANS_IDLE, 1'b0, 32'h0, 1'b0, 1'b0, sel);

    pulseClear();
    @(negedge HCLK);
    checkOutput("clr_err_valid", {31'b0, ERR_VALID}, 32'd0);
    checkOutput("clr_err_addr", ERR_ADDR, 32'd0);
    @(posedge HCLK);
    #1;

    // Watchdog: slave 2 stalls forever, TIMEOUT=8.
    S_HREADYOUT[2] = 1'b0;
    applyStimulus(32'h4000_0100, HTRANS_NONSEQ, 1'b1, 32'hBADDBEEF, 1'b1, 1'b1, sel);
    setIdle();
    stall = 0; tlow = 0; irqn = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge HCLK);
      cyc++;
      if (TOUT_IRQ) irqn++;
      if (HREADY) done = 1'b1;
      else if (HRESP) tlow++;
      else stall++;
    end
    if (!done) failNow("tout_wait");
    checkOutput("tout_stall_cycles", stall, 32'd8);
    checkOutput("tout_err1_cycles", tlow, 32'd1);
    checkOutput("tout_irq_pulses", irqn, 32'd1);
    checkOutput("tout_total_cycles", cyc, 32'd10);
    checkOutput("tout_err_valid", {31'b0, ERR_VALID}, 32'd1);
    checkOutput("tout_err_tout", {31'b0, ERR_TOUT}, 32'd1);
    checkOutput("tout_err_addr", ERR_ADDR, 32'h4000_0100);
    @(posedge HCLK);
    #1;
    S_HREADYOUT[2] = 1'b1;
    @(negedge HCLK);
    checkOutput("tout_irq_after", {31'b0, TOUT_IRQ}, 32'd0);
    @(posedge HCLK);
    #1;

    // Error then mapped write back-to-back: accepted in ERR2, no idle cycle.
    pulseClear();
    applyStimulus(32'hF000_0004, HTRANS_NONSEQ, 1'b1, 32'hBADDBEEF, 1'b1, 1'b1, sel);
    applyStimulus(32'h4000_0000, HTRANS_NONSEQ, 1'b1, 32'h0, 1'b0, 1'b0, sel);
    checkOutput("b2b_hsel", {28'b0, sel}, 32'h4);
    setIdle();
    S_HREADYOUT[2] = 1'b0;
    @(negedge HCLK);
    checkOutput("b2b_no_idle", {31'b0, HREADY}, 32'd0);
    @(posedge HCLK);
    #1;
    S_HREADYOUT[2] = 1'b1;
    applyStimulus(32'h0000_0000, HTRANS_IDLE, 1'b0, 32'h0, 1'b0, 1'b0, sel);

    // Second error keeps the first capture.
    applyStimulus(32'h9000_0000, HTRANS_NONSEQ, 1'b1, 32'hBADDBEEF, 1'b1, 1'b1, sel);
    setIdle();
    applyStimulus(32'h0000_0000, HTRANS_IDLE, 1'b0, 32'h0, 1'b0, 1'b0, sel);
    checkOutput("keep_err_addr", ERR_ADDR, 32'hF000_0004);
    checkOutput("keep_err_valid", {31'b0, ERR_VALID}, 32'd1);
    checkOutput("keep_err_tout", {31'b0, ERR_TOUT}, 32'd0);

    // ERR_CLR in the same cycle as a capture wins; the event is lost.
    pulseClear();
    ERR_CLR = 1'b1;
    applyStimulus(32'hF000_000C, HTRANS_NONSEQ, 1'b1, 32'hBADDBEEF, 1'b1, 1'b1, sel);
    ERR_CLR = 1'b0;
    setIdle();
    @(negedge HCLK);
    checkOutput("clr_prio_err1", {31'b0, ERR_VALID}, 32'd0);
    applyStimulus(32'h0000_0000, HTRANS_IDLE, 1'b0, 32'h0, 1'b0, 1'b0, sel);
    checkOutput("clr_prio_after", {31'b0, ERR_VALID}, 32'd0);

    // Reset during ERR1 abandons the error sequence.
    applyStimulus(32'hF000_0008, HTRANS_NONSEQ, 1'b0, 32'h0, 1'b0, 1'b0, sel);
    HRESET = 1'b1;
    setIdle();
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    checkOutput("mid_rst_hready", {31'b0, HREADY}, 32'd1);
    checkOutput("mid_rst_hresp", {31'b0, HRESP}, 32'd0);
    checkOutput("mid_rst_hrdata", HRDATA, 32'hBADDBEEF);
    checkOutput("mid_rst_err_valid", {31'b0, ERR_VALID}, 32'd0);
    @(posedge HCLK);
    #1;
    @(negedge HCLK);
    checkOutput("mid_rst_no_err2", {31'b0, HRESP}, 32'd0);

    repeat (3) @(posedge HCLK);
    checkOutput("sb_drained", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahbl_splitter_n.md
# ahbl_splitter_n

Parametrised AHB-Lite address splitter connecting one master (the Hazard2 CPU) to up to NSLV slaves on a 4-bit HADDR[31:28] region decode; successor to the fixed four-slave splitter. It adds:
- a built-in default slave that answers unmapped accesses with a two-cycle AHB ERROR;
- a data-phase watchdog that aborts transfers to slaves stalling longer than TIMEOUT cycles;
- sticky error capture for software diagnosis.

## Interface
Parameters:
- NSLV, 4, number of slaves, 1..8.
- SLV_TAGS, {4'h8,4'h4,4'h2,4'h0}, NSLV concatenated 4-bit region tags; slave i uses SLV_TAGS[4i+3:4i].
- TIMEOUT, 255, maximum stall cycles in a slave data phase; 0 disables the watchdog.
- DFLT_RDATA, 32'hBADDBEEF, HRDATA returned by the default slave and after a timeout.

Ports:
- HCLK  in  1  clock; one clock domain.
- HRESET  in  1  synchronous, active-high reset.
- HADDR  in  32  master address.
- HTRANS  in  2  master transfer type; bit 1 qualifies the transfer.
- HREADY  out  1  ready to master and all slaves.
- HRDATA  out  32  read data to master.
- HRESP  out  1  response to master; 0 OKAY, 1 ERROR.
- S_HSEL  out  NSLV  one-hot address-phase select.
- S_HRDATA  in  32*NSLV  slave read data, slave i at [32i+31:32i].
- S_HREADYOUT  in  NSLV  slave ready.
- S_HRESP  in  NSLV  slave response.
- ERR_VALID  out  1  sticky; set on decode error or timeout.
- ERR_TOUT  out  1  1 if the captured error was a timeout, 0 if decode.
- ERR_ADDR  out  32  address of the first faulting transfer since the last clear.
- ERR_CLR  in  1  clears ERR_VALID, ERR_TOUT and ERR_ADDR.
- TOUT_IRQ  out  1  one-cycle pulse when a timeout fires.

## Operation
- Decode is combinational. match_i = (HADDR[31:28] == tag_i). S_HSEL has a one-hot bit set on the lowest matching index, all zero if none. S_HSEL is not qualified by HTRANS; slaves qualify it themselves.
- On a cycle with HREADY=1, the address phase is accepted:
  - Registers capture the selected index, HADDR, and the state for the next data phase.
  - Next state is SLV if HTRANS[1] and a match, ERR1 if HTRANS[1] and no match, otherwise IDLE.
- FSM states: IDLE, SLV, ERR1, ERR2, TOUT1, TOUT2.
  - IDLE: HREADY=1, HRESP=0, HRDATA=DFLT_RDATA.
  - SLV: HREADY, HRESP and HRDATA are muxed from the registered slave index.
  - SLV with S_HREADYOUT low: the stall counter increments each cycle.
  - SLV with counter == TIMEOUT-1 and still low: go to TOUT1.
  - ERR1/TOUT1: HREADY=0, HRESP=1. Always advance to ERR2/TOUT2 next cycle.
  - ERR2/TOUT2: HREADY=1, HRESP=1. The next address phase is accepted here.
- Stall counter: $clog2(TIMEOUT+1) bits. It clears when an address phase is accepted and on reset, and saturates; no wrap.
- Timeout behaviour:
  - TOUT_IRQ pulses during the TOUT1 cycle.
  - From TOUT1 onward the stalled slave's HREADYOUT/HRESP are ignored.
  - A slave that is still stalled is not recovered by the splitter; this is treated as a fatal bus fault.
- Error capture:
  - On entry to ERR1 or TOUT1 with ERR_VALID=0: set ERR_VALID, load ERR_ADDR from the registered data-phase address, set ERR_TOUT = (entering TOUT1).
  - Later errors do not overwrite the capture.
  - ERR_CLR has priority over a same-cycle capture: the register is cleared and that event is lost.
- Slave HRESP=1 is passed through unchanged and does not set ERR_VALID.

## Timing
- Reset values:
  - state=IDLE, counter=0, registered index=0, registered address=0.
  - HREADY=1, HRESP=0, HRDATA=DFLT_RDATA.
  - ERR_VALID=0, ERR_TOUT=0, ERR_ADDR=0, TOUT_IRQ=0.
  - S_HSEL follows HADDR combinationally even during reset.
- Latency:
  - Zero added cycles to mapped slaves. HREADY/HRDATA are combinational from S_* in SLV.
  - Decode error costs exactly 2 data-phase cycles.
  - Timeout response ends TIMEOUT+2 cycles after the data phase starts.
- HRESET asserted mid-transfer returns the block to IDLE on the next edge regardless of state. An interrupted ERR sequence is not completed.
- Back-to-back transfers: an error transfer followed immediately by a mapped transfer accepts the new address in ERR2 and enters SLV with no idle cycle.
- TIMEOUT=0: the counter is unused and SLV waits indefinitely.

## Structure
- Shared package ahbl_pkg holds:
  - state enum (6 states);
  - HRESP_OKAY/HRESP_ERROR;
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ;
  - REGION_W=4;
  - the default DFLT_RDATA constant.
- Sub-module ahbl_default_slave implements the ERR1→ERR2 sequencing. It is instantiated once and triggered by both the decode-error and timeout paths; ERR_TOUT distinguishes them.

## Test plan
- Read 0x0000_0010 (slave 0, HREADYOUT=1, data 0x1234_5678) → S_HSEL=4'b0001; next cycle HRDATA=0x1234_5678, HREADY=1, HRESP=0.
- NONSEQ to 0xF000_0000 (unmapped) → cycle 1 HREADY=0/HRESP=1, cycle 2 HREADY=1/HRESP=1, HRDATA=0xBADDBEEF; ERR_VALID=1, ERR_TOUT=0, ERR_ADDR=0xF000_0000.
- TIMEOUT=8, slave 2 holds HREADYOUT=0 → HREADY low 8 cycles, TOUT_IRQ pulses once, ERROR pair follows; ERR_TOUT=1 (after ERR_CLR).
- Unmapped access then write to 0x4000_0000 back-to-back → address accepted in ERR2, slave 2 sees HSEL with HREADY=1, no idle cycle; ERR_ADDR keeps the first fault after a second error.
- HRESET asserted in ERR1 → next cycle HREADY=1, HRESP=0, state IDLE; ERR_VALID=0.
- Overlapping tags (slaves 0 and 3 both 4'h0) → only S_HSEL[0] asserted.
